full_logic_param: RTL and testbench

- Parametrised successor of the two-channel transmit-layer logic block.
- Incoming words are written into a main FIFO, then routed by destination bits into NUM_CH output FIFOs, each with its own pop port.
- Programmable almost-full thresholds are captured during INIT and drive backpressure.
- A control FSM reports init/idle/active/error status to the upstream link logic.

---
 rtl/full_logic_param.sv | 198 +++++++++++++++++++
 tb/tb_full_logic_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/full_logic_param.sv
// full_logic_param: parametrised transmit-layer logic block.
//   Words written into a main FIFO are routed by their top DEST_WIDTH bits
//   into NUM_CH channel FIFOs, each with its own pop port. The almost-full
//   thresholds are captured while in INIT and throttle the main->channel
//   transfer. A control FSM reports init/idle/active/error status.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   init                request threshold programming
//   umbral_main/_ch     main / per-channel almost-full thresholds (CW bits)
//   wr_enable, data_in  main FIFO write port
//   pop                 per-channel pop request (NUM_CH bits)
//   data_out, valid_out per-channel registered output word and strobe
//   empty_ch            per-channel empty flag
//   almost_full_main    main count >= effective main threshold
//   error_ch            sticky pop-while-empty flag per channel
//   error_out, active_out, idle_out, init_out   one-hot FSM status
//
// Build option: define FULL_LOGIC_ERROR_RECOVER_EN to let init=1 in ERROR
// flush all FIFOs and return to INIT; otherwise ERROR is left only by reset.

module full_logic_param #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_WIDTH = 1,
    parameter int FIFO_DEPTH = 8,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1,
    localparam int NUM_CH    = 2 ** DEST_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic [CW-1:0]                umbral_main,
    input  logic [CW-1:0]                umbral_ch,
    input  logic                         wr_enable,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [NUM_CH-1:0]            pop,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            valid_out,
    output logic [NUM_CH-1:0]            empty_ch,
    output logic                         almost_full_main,
    output logic [NUM_CH-1:0]            error_ch,
    output logic                         error_out,
    output logic                         active_out,
    output logic                         idle_out,
    output logic                         init_out
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_INIT,
        ST_IDLE,
        ST_ACTIVE,
        ST_ERROR
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] main_mem [FIFO_DEPTH];
    logic [AW-1:0]         main_rd, main_wr;
    logic [CW-1:0]         main_cnt;
    logic [CW-1:0]         ch_cnt [NUM_CH];

    logic [CW-1:0]         thr_main, thr_ch, eff_main, eff_ch;
    logic [DATA_WIDTH-1:0] head;
    logic [DEST_WIDTH-1:0] head_dest;
    logic                  xfer, wr_allowed, main_push, wr_overflow;
    logic                  err_ev, flush, any_nonempty;
    logic [NUM_CH-1:0]     ch_push, ch_pop, pop_err, ch_nonempty;

    // A zero or out-of-range threshold means "no early backpressure".
    assign eff_main = (thr_main == '0 || thr_main > CW'(FIFO_DEPTH)) ? CW'(FIFO_DEPTH) : thr_main;
    assign eff_ch   = (thr_ch   == '0 || thr_ch   > CW'(FIFO_DEPTH)) ? CW'(FIFO_DEPTH) : thr_ch;

    assign head      = main_mem[main_rd];
    assign head_dest = head[DATA_WIDTH-1 -: DEST_WIDTH];

    // Head-of-line: only the head word may move; a blocked head stalls all.
    assign xfer        = (main_cnt != '0) && (ch_cnt[head_dest] < eff_ch);
    assign wr_allowed  = (state == ST_IDLE) || (state == ST_ACTIVE);
    // Full is judged after the same-cycle transfer frees a slot.
    assign wr_overflow = wr_allowed && wr_enable && (main_cnt == CW'(FIFO_DEPTH)) && !xfer;
    assign main_push   = wr_allowed && wr_enable && !wr_overflow;

    assign err_ev       = wr_overflow || (|pop_err);
    assign any_nonempty = (main_cnt != '0) || (|ch_nonempty);

`ifdef FULL_LOGIC_ERROR_RECOVER_EN
    assign flush = (state == ST_ERROR) && init;
`else
    assign flush = 1'b0;
`endif

    assign almost_full_main = (main_cnt >= eff_main);

    assign init_out   = (state == ST_INIT);
    assign idle_out   = (state == ST_IDLE);
    assign active_out = (state == ST_ACTIVE);
    assign error_out  = (state == ST_ERROR);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   if (!init) state_nxt = ST_IDLE;
            ST_IDLE:   if (init) state_nxt = ST_INIT;
                       else if (any_nonempty) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (init) state_nxt = ST_INIT;
                       else if (!any_nonempty) state_nxt = ST_IDLE;
            ST_ERROR:  if (flush) state_nxt = ST_INIT;
            default:   state_nxt = ST_RESET;
        endcase
        if (err_ev && (state != ST_RESET) && !flush)
            state_nxt = ST_ERROR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RESET;
            thr_main <= CW'(FIFO_DEPTH);
            thr_ch   <= CW'(FIFO_DEPTH);
            main_rd  <= '0;
            main_wr  <= '0;
            main_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                thr_main <= umbral_main;
                thr_ch   <= umbral_ch;
            end
            if (flush) begin
                main_rd  <= '0;
                main_wr  <= '0;
                main_cnt <= '0;
            end else begin
                if (xfer)      main_rd <= main_rd + AW'(1);
                if (main_push) main_wr <= main_wr + AW'(1);
                unique case ({main_push, xfer})
                    2'b10:   main_cnt <= main_cnt + CW'(1);
                    2'b01:   main_cnt <= main_cnt - CW'(1);
                    default: main_cnt <= main_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (main_push) main_mem[main_wr] <= data_in;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]         rd, wr;
        logic [CW-1:0]         cnt;

        assign ch_cnt[g]      = cnt;
        assign ch_nonempty[g] = (cnt != '0);
        assign empty_ch[g]    = (cnt == '0);
        assign ch_push[g]     = xfer && (head_dest == DEST_WIDTH'(g));
        assign ch_pop[g]      = pop[g] && (cnt != '0) && (state != ST_RESET);
        assign pop_err[g]     = pop[g] && (cnt == '0) && (state != ST_RESET);

        always_ff @(posedge clk) begin
            if (ch_push[g]) mem[wr] <= head;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd                                 <= '0;
                wr                                 <= '0;
                cnt                                <= '0;
                data_out[g*DATA_WIDTH +: DATA_WIDTH] <= '0;
                valid_out[g]                       <= 1'b0;
                error_ch[g]                        <= 1'b0;
            end else begin
                valid_out[g] <= ch_pop[g];
                if (ch_pop[g]) data_out[g*DATA_WIDTH +: DATA_WIDTH] <= mem[rd];
                if (flush) begin
                    rd          <= '0;
                    wr          <= '0;
                    cnt         <= '0;
                    error_ch[g] <= 1'b0;
                end else begin
                    if (pop_err[g]) error_ch[g] <= 1'b1;
                    if (ch_pop[g])  rd <= rd + AW'(1);
                    if (ch_push[g]) wr <= wr + AW'(1);
                    unique case ({ch_push[g], ch_pop[g]})
                        2'b10:   cnt <= cnt + CW'(1);
                        2'b01:   cnt <= cnt - CW'(1);
                        default: cnt <= cnt;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_full_logic_param.sv
// Directed self-checking bench for full_logic_param (default parameters:
// 6-bit words, 1 destination bit, 2 channels, depth 8).

module tb_full_logic_param;

    localparam int DW    = 6;
    localparam int DESTW = 1;
    localparam int DEPTH = 8;
    localparam int NCH   = 2;
    localparam int CW    = 4;

    logic              clk = 1'b0;
    logic              reset, init, wr_enable;
    logic [CW-1:0]     umbral_main, umbral_ch;
    logic [DW-1:0]     data_in;
    logic [NCH-1:0]    pop;
    logic [NCH*DW-1:0] data_out;
    logic [NCH-1:0]    valid_out, empty_ch, error_ch;
    logic              almost_full_main, error_out, active_out, idle_out, init_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    full_logic_param #(
        .DATA_WIDTH(DW),
        .DEST_WIDTH(DESTW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .init(init),
        .umbral_main(umbral_main),
        .umbral_ch(umbral_ch),
        .wr_enable(wr_enable),
        .data_in(data_in),
        .pop(pop),
        .data_out(data_out),
        .valid_out(valid_out),
        .empty_ch(empty_ch),
        .almost_full_main(almost_full_main),
        .error_ch(error_ch),
        .error_out(error_out),
        .active_out(active_out),
        .idle_out(idle_out),
        .init_out(init_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_init(input logic [CW-1:0] um, input logic [CW-1:0] uc);
        reset = 1'b1; init = 1'b0; wr_enable = 1'b0; pop = '0; data_in = '0;
        tick; tick;
        reset = 1'b0; init = 1'b1; umbral_main = um; umbral_ch = uc;
        tick; tick;
        init = 1'b0;
        tick;
    endtask

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: observed timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; init = 1'b0; wr_enable = 1'b0; pop = '0; data_in = '0;
        umbral_main = '0; umbral_ch = '0;
        tick; tick;

        // Reset state
        check("rst_status", {init_out, idle_out, active_out, error_out}, 4'b0000);
        check("rst_empty", empty_ch, 2'b11);
        check("rst_valid", valid_out, 2'b00);
        check("rst_dout", data_out, 12'h000);
        check("rst_errch", error_ch, 2'b00);
        check("rst_afull", almost_full_main, 1'b0);

        // Threshold programming
        reset = 1'b0; init = 1'b1; umbral_main = 4'd6; umbral_ch = 4'd3;
        tick;
        check("init_1", init_out, 1'b1);
        tick;
        check("init_2", init_out, 1'b1);
        init = 1'b0;
        tick;
        check("idle_after_init", {init_out, idle_out, active_out, error_out}, 4'b0100);

        // Basic routing and pops
        wr_enable = 1'b1; data_in = 6'h05;
        tick;
        check("empty_k1", empty_ch, 2'b11);
        data_in = 6'h22;
        tick;
        check("empty_k2", empty_ch, 2'b10);
        check("active_k2", active_out, 1'b1);
        data_in = 6'h07;
        tick;
        check("empty_k3", empty_ch, 2'b00);
        wr_enable = 1'b0;
        tick;
        pop = 2'b01;
        tick;
        check("pop0_a_data", data_out[DW-1:0], 6'h05);
        check("pop0_a_valid", valid_out, 2'b01);
        tick;
        check("pop0_b_data", data_out[DW-1:0], 6'h07);
        check("pop0_b_valid", valid_out, 2'b01);
        pop = 2'b10;
        tick;
        check("pop1_dout", data_out, 12'h887);
        check("pop1_valid", valid_out, 2'b10);
        pop = 2'b00;
        tick;
        check("back_idle", {idle_out, active_out}, 2'b10);
        check("valid_clear", valid_out, 2'b00);
        check("empty_all", empty_ch, 2'b11);

        // Channel threshold blocking, main almost-full, overflow
        wr_enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            data_in = DW'(i);
            tick;
        end
        check("afull_at5", almost_full_main, 1'b0);
        check("blocked_empty", empty_ch, 2'b10);
        data_in = 6'h09;
        tick;
        check("afull_at6", almost_full_main, 1'b1);
        data_in = 6'h0A;
        tick;
        data_in = 6'h0B;
        tick;
        check("no_err_at8", error_out, 1'b0);
        data_in = 6'h0C;
        tick;
        check("overflow_err", error_out, 1'b1);

        // Drain in ERROR; writes are dropped and the overflow word never shows
        data_in = 6'h1E;
        pop = 2'b01;
        for (int k = 0; k < 11; k++) begin
            tick;
            check("drain_valid", valid_out, 2'b01);
            check("drain_data", data_out[DW-1:0], 32'(k + 1));
        end
        pop = 2'b00; wr_enable = 1'b0;
        tick;
        check("drain_empty", empty_ch, 2'b11);
        check("drain_err", error_out, 1'b1);
        check("drain_errch", error_ch, 2'b00);

        // Pop on an empty channel
        reset_init(4'd6, 4'd3);
        check("idle_re", idle_out, 1'b1);
        pop = 2'b10;
        tick;
        check("popempty_errch", error_ch, 2'b10);
        check("popempty_err", error_out, 1'b1);
        check("popempty_valid", valid_out, 2'b00);
        pop = 2'b00; wr_enable = 1'b1; data_in = 6'h05;
        tick; tick;
        wr_enable = 1'b0;
        tick;
        check("err_wr_dropped", empty_ch, 2'b11);
`ifdef FULL_LOGIC_ERROR_RECOVER_EN
        init = 1'b1;
        tick;
        check("recover_init", {init_out, error_out}, 2'b10);
        check("recover_errch", error_ch, 2'b00);
        init = 1'b0;
        tick;
        check("recover_idle", idle_out, 1'b1);
`else
        init = 1'b1;
        tick;
        check("sticky_err", error_out, 1'b1);
        check("sticky_errch", error_ch, 2'b10);
        init = 1'b0; reset = 1'b1;
        tick;
        check("rst_clr_errch", error_ch, 2'b00);
        check("rst_clr_err", error_out, 1'b0);
`endif

        // Zero thresholds behave as the full depth
        reset_init(4'd0, 4'd0);
        check("thr0_afull", almost_full_main, 1'b0);
        wr_enable = 1'b1; data_in = 6'h21;
        tick;
        wr_enable = 1'b0;
        tick;
        check("thr0_xfer", empty_ch, 2'b01);
        pop = 2'b10;
        tick;
        check("thr0_data", data_out[2*DW-1:DW], 6'h21);
        check("thr0_valid", valid_out, 2'b10);
        pop = 2'b00;

        // Streaming with simultaneous push/pop on channel 0 at count 2
        reset_init(4'd6, 4'd3);
        wr_enable = 1'b1;
        data_in = 6'h01; tick;
        data_in = 6'h02; tick;
        data_in = 6'h03; tick;
        pop = 2'b01;
        for (int k = 0; k < 6; k++) begin
            data_in = DW'(4 + k);
            tick;
            check("stream_valid", valid_out, 2'b01);
            check("stream_data", data_out[DW-1:0], 32'(k + 1));
        end
        wr_enable = 1'b0;
        for (int k = 6; k < 9; k++) begin
            tick;
            check("tail_data", data_out[DW-1:0], 32'(k + 1));
        end
        pop = 2'b00;
        tick;
        check("stream_empty", empty_ch, 2'b11);
        check("stream_errch", error_ch, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
